// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg - shared encodings for the two-port stack arbiter.
// Rev 1.0 - initial release.
`default_nettype none

package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2 - two-way round-robin grant; on a tie the port not served last wins.
// Rev 1.0 - initial release.
`default_nettype none

module rr_arbiter2
  import stack_ctrl_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic rr_last,
  output logic valid,
  output logic sel
);

  always_comb begin
    valid = a_req | b_req;
    sel   = PORT_A;
    if (a_req && b_req) begin
      sel = (rr_last == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      sel = PORT_B;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stack_port_arbiter.sv
// stack_port_arbiter - shares one LIFO engine between ports A and B, one op at a time.
// Rev 1.0 - initial release.
`default_nettype none

module stack_port_arbiter
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_done,
  input  logic              stk_empty,
  input  logic              stk_full
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t             state, state_nxt;
  logic               sel;
  logic               op;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic               rr_last;

  logic               gnt_valid;
  logic               gnt_sel;
  logic               gnt_op;
  logic [DATA_W-1:0]  gnt_wdata;
  logic               reject;

  rr_arbiter2 u_arb (
    .a_req   (a_req),
    .b_req   (b_req),
    .rr_last (rr_last),
    .valid   (gnt_valid),
    .sel     (gnt_sel)
  );

  assign gnt_op    = (gnt_sel == PORT_B) ? b_op    : a_op;
  assign gnt_wdata = (gnt_sel == PORT_B) ? b_wdata : a_wdata;
  // Flags are only trusted here; an op that cannot complete never reaches the engine.
  assign reject    = ((gnt_op == OP_PUSH) && stk_full) || ((gnt_op == OP_POP) && stk_empty);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = reject ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (stk_done || (cnt == TIMEOUT_CNT)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= PORT_A;
      op      <= OP_POP;
      wdata_q <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      rr_last <= PORT_B;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            sel     <= gnt_sel;
            op      <= gnt_op;
            wdata_q <= gnt_wdata;
            err     <= reject;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (stk_done) begin
            err <= 1'b0;
            if (op == OP_POP) rdata <= stk_rdata;
          end else if (cnt == TIMEOUT_CNT) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: rr_last <= sel;
        default: ;
      endcase
    end
  end

  assign stk_push  = (state == ISSUE) && (op == OP_PUSH);
  assign stk_pop   = (state == ISSUE) && (op == OP_POP);
  assign stk_wdata = wdata_q;

  assign a_ack = (state == RESP) && (sel == PORT_A);
  assign b_ack = (state == RESP) && (sel == PORT_B);
  assign a_err = a_ack && err;
  assign b_err = b_ack && err;

endmodule

`default_nettype wire

// File: tb/tb_stack_port_arbiter.sv
// tb_stack_port_arbiter - directed bench with a small LIFO engine model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_stack_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_op, b_req, b_op;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] rdata;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_done;
  logic       stk_empty, stk_full;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [$];
  int         n_push = 0;
  int         n_pop  = 0;
  logic       mute   = 1'b0;

  stack_port_arbiter #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_op      (a_op),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_op      (b_op),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_err     (b_err),
    .rdata     (rdata),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_done  (stk_done),
    .stk_empty (stk_empty),
    .stk_full  (stk_full)
  );

  always #5 clk = ~clk;

  // Engine model: completes every strobe on the following cycle unless muted.
  always @(posedge clk) begin
    stk_done <= 1'b0;
    if (stk_push) n_push <= n_push + 1;
    if (stk_pop)  n_pop  <= n_pop + 1;
    if (rst) begin
      mem.delete();
      stk_rdata <= 8'h00;
    end else if (!mute) begin
      if (stk_push) begin
        mem.push_back(stk_wdata);
        stk_done <= 1'b1;
      end
      if (stk_pop && mem.size() > 0) begin
        stk_rdata <= mem.pop_back();
        stk_done  <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_req = 0; a_op = 0; a_wdata = 0; b_req = 0; b_op = 0; b_wdata = 0;
    stk_empty = 0; stk_full = 0; stk_done = 0; stk_rdata = 0;

    // Reset state
    do_reset();
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_push",  {31'd0, stk_push}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_wdata", {24'd0, stk_wdata}, 32'h00);

    // 1: single push, ack three cycles after the grant cycle
    a_req = 1; a_op = 1; a_wdata = 8'h5A;
    tick();
    a_wdata = 8'h00;
    chk("t1_push",  {31'd0, stk_push}, 32'd1);
    chk("t1_wdata", {24'd0, stk_wdata}, 32'h5A);
    chk("t1_noack", {31'd0, a_ack}, 32'd0);
    tick();
    chk("t1_push_once", {31'd0, stk_push}, 32'd0);
    chk("t1_wdata_hold", {24'd0, stk_wdata}, 32'h5A);
    chk("t1_noack2", {31'd0, a_ack}, 32'd0);
    tick();
    chk("t1_ack", {31'd0, a_ack}, 32'd1);
    chk("t1_err", {31'd0, a_err}, 32'd0);
    chk("t1_b_ack", {31'd0, b_ack}, 32'd0);
    a_req = 0;
    tick();
    chk("t1_ack_pulse", {31'd0, a_ack}, 32'd0);
    chk("t1_npush", n_push, 32'd1);

    // 2: simultaneous pushes after reset; A wins, then B
    do_reset();
    a_req = 1; a_op = 1; a_wdata = 8'h11;
    b_req = 1; b_op = 1; b_wdata = 8'h22;
    tick();
    chk("t2_push_a", {31'd0, stk_push}, 32'd1);
    chk("t2_wdata_a", {24'd0, stk_wdata}, 32'h11);
    tick();
    tick();
    chk("t2_a_ack", {31'd0, a_ack}, 32'd1);
    chk("t2_b_wait", {31'd0, b_ack}, 32'd0);
    a_req = 0;
    tick();
    tick();
    chk("t2_push_b", {31'd0, stk_push}, 32'd1);
    chk("t2_wdata_b", {24'd0, stk_wdata}, 32'h22);
    tick();
    tick();
    chk("t2_b_ack", {31'd0, b_ack}, 32'd1);
    chk("t2_b_err", {31'd0, b_err}, 32'd0);
    chk("t2_a_idle", {31'd0, a_ack}, 32'd0);
    b_req = 0;
    tick();
    chk("t2_npush", n_push, 32'd3);

    // 3: simultaneous pops; A first since B was served last
    a_req = 1; a_op = 0; b_req = 1; b_op = 0;
    tick();
    chk("t3_pop_a", {31'd0, stk_pop}, 32'd1);
    chk("t3_nopush", {31'd0, stk_push}, 32'd0);
    tick();
    tick();
    chk("t3_a_ack", {31'd0, a_ack}, 32'd1);
    chk("t3_a_rdata", {24'd0, rdata}, 32'h22);
    chk("t3_a_err", {31'd0, a_err}, 32'd0);
    a_req = 0;
    tick();
    tick();
    chk("t3_pop_b", {31'd0, stk_pop}, 32'd1);
    tick();
    tick();
    chk("t3_b_ack", {31'd0, b_ack}, 32'd1);
    chk("t3_b_rdata", {24'd0, rdata}, 32'h11);
    b_req = 0;
    tick();
    chk("t3_npop", n_pop, 32'd2);

    // 4: pop while empty is rejected one cycle after grant
    stk_empty = 1;
    a_req = 1; a_op = 0;
    tick();
    chk("t4_a_ack", {31'd0, a_ack}, 32'd1);
    chk("t4_a_err", {31'd0, a_err}, 32'd1);
    chk("t4_nopop", {31'd0, stk_pop}, 32'd0);
    chk("t4_rdata", {24'd0, rdata}, 32'h11);
    a_req = 0;
    tick();
    chk("t4_npop", n_pop, 32'd2);
    stk_empty = 0;

    // 5: push while full is rejected
    stk_full = 1;
    b_req = 1; b_op = 1; b_wdata = 8'hFF;
    tick();
    chk("t5_b_ack", {31'd0, b_ack}, 32'd1);
    chk("t5_b_err", {31'd0, b_err}, 32'd1);
    chk("t5_nopush", {31'd0, stk_push}, 32'd0);
    b_req = 0;
    tick();
    chk("t5_npush", n_push, 32'd3);
    stk_full = 0;

    // 6a: engine never completes; error after 16 WAIT cycles (cnt 0..15)
    mute = 1;
    b_req = 1; b_op = 1; b_wdata = 8'h33;
    tick();
    chk("t6_push", {31'd0, stk_push}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t6_wait%0d", i), {30'd0, b_ack, stk_push}, 32'd0);
    end
    tick();
    chk("t6_b_ack", {31'd0, b_ack}, 32'd1);
    chk("t6_b_err", {31'd0, b_err}, 32'd1);
    b_req = 0;
    tick();
    chk("t6_ack_pulse", {31'd0, b_ack}, 32'd0);

    // 6b: reset mid-WAIT abandons the op with no ack
    a_req = 1; a_op = 1; a_wdata = 8'h44;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    chk("t6r_ack", {31'd0, a_ack}, 32'd0);
    chk("t6r_rdata", {24'd0, rdata}, 32'h00);
    rst = 0; a_req = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("t6r_noack%0d", i), {30'd0, a_ack, b_ack}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
